ex_stage: RTL and testbench
===========================

# ex_stage

Execute-stage sequencer for the 554 CPU, sitting directly upstream of the combinational `alu`. It accepts decoded operations from the decode stage over a valid/ready handshake and drives `a`/`b`/`opcode` into the ALU. It holds operands stable for the multi-cycle MUL/DIV paths, then captures `alu_out` and `flags` into an output register for the memory stage. It also owns the architectural flags register.

## Interface
- `DATA_W`, 32: operand/result width.
- `MUL_CYC`, 2: cycles ALU inputs are held for MUL (≥1).
- `DIV_CYC`, 8: cycles ALU inputs are held for DIV (≥1).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous kill of the in-flight operation.
- `in_valid` in 1, `in_ready` out 1: decode handshake.
- `in_opcode` in 5, `in_a` in DATA_W, `in_b` in DATA_W, `in_rd` in 5: operation, operands, destination register.
- `alu_a` out DATA_W, `alu_b` out DATA_W, `alu_opcode` out 5: drive the ALU.
- `alu_out` in DATA_W, `alu_flags` in 2: ALU result. `alu_flags[1]` is zero; `alu_flags[0]` is negative.
- `out_valid` out 1, `out_ready` in 1: memory-stage handshake.
- `out_result` out DATA_W, `out_rd` out 5, `out_opcode` out 5: captured result.
- `out_wb` out 1: result is to be written to `out_rd`.
- `out_illegal` out 1: opcode is not in the defined set.
- `flags_q` out 2: architectural flags register, same bit order as `alu_flags`.
- `busy` out 1: an operation occupies the op register.

## Operation
- Opcodes: ADD 00010, ADDI 00011, SUB 00100, SUBI 00101, MUL 00110, MOVEH 00111, DIV 01000, AND 01010, ANDI 01011, OR 01100, ORI 01101, NOT 01110, XOR 10000, XORI 10001, CMP 10010, CALL 11001, RET 11010, RETI 11011, ST 11100, LD 11101, MOVEL 11110. All other opcodes are illegal.
- Op-register FSM states:
  - IDLE: no operation held.
  - COUNT: `cnt` > 0.
  - DONE: `cnt` == 0, result not yet captured.
- Accept on `in_valid && in_ready`:
  - Load the op register.
  - Load `cnt` = L−1, where L = MUL_CYC for MUL, DIV_CYC for DIV, and 1 for everything else, including illegal opcodes.
  - Next state is COUNT if L > 1, else DONE.
- In COUNT, `cnt` decrements each cycle; the FSM moves to DONE when `cnt` reaches 0.
- Capture condition: `capture = DONE && (!out_valid || out_ready)`.
- On capture:
  - Output register ← `alu_out`, rd, opcode, `wb`, `illegal`.
  - `out_valid` ← 1.
  - FSM returns to IDLE unless a new operation is accepted in the same cycle.
- `in_ready = !rst && !flush && (IDLE || capture)`. Back-to-back single-cycle operations sustain one per cycle.
- `out_valid` clears on `out_ready` unless a capture happens in the same cycle; a capture in that cycle refills the output register.
- `alu_a`, `alu_b`, `alu_opcode` come from the op register and are constant for the whole COUNT/DONE residency. They are 0 in IDLE.
- `flags_q` ← `alu_flags` on capture for ADD, ADDI, SUB, SUBI, MUL, DIV, AND, ANDI, OR, ORI, NOT, XOR, XORI, CMP. Every other opcode leaves `flags_q` unchanged.
- `out_wb` = 0 for CMP, ST, CALL, RET, RETI and illegal opcodes; 1 otherwise.
- `flush`:
  - Returns the FSM to IDLE and zeroes `cnt`.
  - Suppresses a capture in the same cycle.
  - Does not touch the output register or `flags_q`.
- `busy` = FSM not in IDLE.

## Timing
- Reset: every output is 0, FSM is IDLE, `cnt` is 0. Reset mid-operation discards the operation and the pending output.
- Handshake in cycle 0 → ALU driven cycles 1..L → `out_valid` in cycle L+1.
- Output stall: the FSM holds DONE, operands stay stable, and `in_ready` stays 0.
- Producers must hold all `in_*` stable while `in_valid && !in_ready`. Same rule applies to the consumer side for `out_*` until `out_ready`.
- `flags_q` is visible from the cycle after capture.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode localparams.
  - The 2-bit flag bit-index constants.
  - The FSM state enum.
- Sub-module `ex_op_decode` (combinational), mapping opcode → {latency class, sets_flags, wb, illegal}.

## Test plan
- ADD a=5, b=7, `out_ready`=1 → `alu_a`=5 and `alu_b`=7 in cycle 1; `out_valid` in cycle 2 with `out_result` 12 and `out_wb` 1; `flags_q` becomes 00.
- CMP 9 vs 9, then LD → after CMP, `flags_q` = 10 (zero set) and CMP `out_wb` = 0; LD leaves `flags_q` at 10.
- DIV 100/7 with DIV_CYC=8 → `alu_*` stable for cycles 1–8; `in_ready` = 0 during cycles 1–7; `out_result` = 14 in cycle 9.
- Four back-to-back ADDs with `out_ready`=1 → `out_valid` high four consecutive cycles. Then hold `out_ready`=0 → FSM sits in DONE and `in_ready` = 0.
- MUL accepted, `flush` in cycle 1 → no `out_valid`, `flags_q` unchanged, `in_ready` high in cycle 2.
- Opcode 01001 → `out_illegal` = 1, `out_wb` = 0, `flags_q` unchanged. Then `rst` asserted mid-DIV → all outputs 0 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 554 CPU execute path.
// Holds the opcode map, the flag bit positions and the execute-stage FSM states.
// Latency classes select how long the ALU inputs are held for an operation.
package cpu_pkg;

    // Opcode map; any encoding not listed here is illegal.
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_SUBI  = 5'b00101;
    localparam logic [4:0] OP_MUL   = 5'b00110;
    localparam logic [4:0] OP_MOVEH = 5'b00111;
    localparam logic [4:0] OP_DIV   = 5'b01000;
    localparam logic [4:0] OP_AND   = 5'b01010;
    localparam logic [4:0] OP_ANDI  = 5'b01011;
    localparam logic [4:0] OP_OR    = 5'b01100;
    localparam logic [4:0] OP_ORI   = 5'b01101;
    localparam logic [4:0] OP_NOT   = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b10000;
    localparam logic [4:0] OP_XORI  = 5'b10001;
    localparam logic [4:0] OP_CMP   = 5'b10010;
    localparam logic [4:0] OP_CALL  = 5'b11001;
    localparam logic [4:0] OP_RET   = 5'b11010;
    localparam logic [4:0] OP_RETI  = 5'b11011;
    localparam logic [4:0] OP_ST    = 5'b11100;
    localparam logic [4:0] OP_LD    = 5'b11101;
    localparam logic [4:0] OP_MOVEL = 5'b11110;

    // Bit positions inside the 2-bit flags vector.
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Latency classes produced by the opcode decoder.
    localparam logic [1:0] LAT_ONE = 2'd0;
    localparam logic [1:0] LAT_MUL = 2'd1;
    localparam logic [1:0] LAT_DIV = 2'd2;

    // Op-register FSM.
    //   ST_IDLE  : nothing held
    //   ST_COUNT : operands held, cnt > 0
    //   ST_DONE  : cnt == 0, waiting for the output register to take the result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } ex_state_t;

endpackage

// File: rtl/ex_op_decode.sv
// Opcode classifier: latency class, flag update, writeback and legality.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows opcode directly.
//
// Ports:
//   opcode      in  5  operation code
//   lat_class   out 2  LAT_ONE / LAT_MUL / LAT_DIV
//   sets_flags  out 1  result updates the architectural flags
//   wb          out 1  result is written to the destination register
//   illegal     out 1  opcode is outside the defined set
module ex_op_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [1:0] lat_class,
    output logic       sets_flags,
    output logic       wb,
    output logic       illegal
);

    always_comb begin
        lat_class  = LAT_ONE;
        sets_flags = 1'b0;
        wb         = 1'b1;
        illegal    = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
            OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_NOT,
            OP_XOR, OP_XORI: begin
                sets_flags = 1'b1;
            end
            OP_MUL: begin
                lat_class  = LAT_MUL;
                sets_flags = 1'b1;
            end
            OP_DIV: begin
                lat_class  = LAT_DIV;
                sets_flags = 1'b1;
            end
            // Compare only produces flags; there is no register result.
            OP_CMP: begin
                sets_flags = 1'b1;
                wb         = 1'b0;
            end
            OP_CALL, OP_RET, OP_RETI, OP_ST: begin
                wb = 1'b0;
            end
            OP_MOVEH, OP_MOVEL, OP_LD: begin
                wb = 1'b1;
            end
            default: begin
                illegal = 1'b1;
                wb      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute-stage sequencer: holds operands on the ALU for 1/MUL_CYC/DIV_CYC cycles and registers the result.
// Latency: accept in cycle 0, ALU driven cycles 1..L, out_valid in cycle L+1; one op per cycle when L=1.
// Backpressure: out_ready low stalls the FSM in DONE with operands held and in_ready low.
//
// Ports:
//   clk, rst (sync, active-high), flush (kills the in-flight op)
//   in_valid/in_ready, in_opcode, in_a, in_b, in_rd     : decode handshake
//   alu_a, alu_b, alu_opcode / alu_out, alu_flags      : combinational ALU
//   out_valid/out_ready, out_result, out_rd, out_opcode,
//   out_wb, out_illegal                                : memory-stage handshake
//   flags_q : architectural flags, busy : op register occupied
module ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_rd,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [1:0]        alu_flags,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_opcode,
    output logic              out_wb,
    output logic              out_illegal,

    output logic [1:0]        flags_q,
    output logic              busy
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    // cnt only ever holds L-1, so MAX_CYC-1 must fit.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    ex_state_t          state;
    logic [CNT_W-1:0]   cnt;

    // Op register: operands plus the decoded attributes needed at capture.
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [4:0]         op_opcode;
    logic [4:0]         op_rd;
    logic               op_sets_flags;
    logic               op_wb;
    logic               op_illegal;

    logic [1:0]         dec_lat;
    logic               dec_sets_flags;
    logic               dec_wb;
    logic               dec_illegal;

    logic               capture;
    logic               accept;
    logic [CNT_W-1:0]   load_cnt;

    ex_op_decode u_dec (
        .opcode     (in_opcode),
        .lat_class  (dec_lat),
        .sets_flags (dec_sets_flags),
        .wb         (dec_wb),
        .illegal    (dec_illegal)
    );

    // The output register can take the result when it is empty or being drained this cycle.
    assign capture  = (state == ST_DONE) && (!out_valid || out_ready) && !flush;
    // Accepting alongside a capture keeps single-cycle ops flowing at one per cycle.
    assign in_ready = !rst && !flush && ((state == ST_IDLE) || capture);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    // The op register is cleared whenever the FSM goes idle, so the ALU sees zeros then.
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_opcode = op_opcode;

    always_comb begin
        load_cnt = '0;
        case (dec_lat)
            LAT_MUL: load_cnt = CNT_W'(MUL_CYC - 1);
            LAT_DIV: load_cnt = CNT_W'(DIV_CYC - 1);
            default: load_cnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_opcode     <= '0;
            op_rd         <= '0;
            op_sets_flags <= 1'b0;
            op_wb         <= 1'b0;
            op_illegal    <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_opcode    <= '0;
            out_wb        <= 1'b0;
            out_illegal   <= 1'b0;
            flags_q       <= '0;
        end else begin
            // Op register and FSM. in_ready is low under flush, so flush and accept never coincide.
            if (flush) begin
                state         <= ST_IDLE;
                cnt           <= '0;
                op_a          <= '0;
                op_b          <= '0;
                op_opcode     <= '0;
                op_rd         <= '0;
                op_sets_flags <= 1'b0;
                op_wb         <= 1'b0;
                op_illegal    <= 1'b0;
            end else if (accept) begin
                state         <= (load_cnt != '0) ? ST_COUNT : ST_DONE;
                cnt           <= load_cnt;
                op_a          <= in_a;
                op_b          <= in_b;
                op_opcode     <= in_opcode;
                op_rd         <= in_rd;
                op_sets_flags <= dec_sets_flags;
                op_wb         <= dec_wb;
                op_illegal    <= dec_illegal;
            end else if (capture) begin
                state         <= ST_IDLE;
                cnt           <= '0;
                op_a          <= '0;
                op_b          <= '0;
                op_opcode     <= '0;
                op_rd         <= '0;
                op_sets_flags <= 1'b0;
                op_wb         <= 1'b0;
                op_illegal    <= 1'b0;
            end else if (state == ST_COUNT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state <= ST_DONE;
                end
            end

            // Output register: a capture refills it even while the previous result drains.
            if (capture) begin
                out_valid   <= 1'b1;
                out_result  <= alu_out;
                out_rd      <= op_rd;
                out_opcode  <= op_opcode;
                out_wb      <= op_wb;
                out_illegal <= op_illegal;
                if (op_sets_flags) begin
                    flags_q <= alu_flags;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a behavioural ALU and an in-order result scoreboard.
// Latency: drives one op per cycle at most; checks sampled on the falling clock edge.
// Backpressure: out_ready is toggled by the directed steps to exercise output stalls.
module tb_ex_stage;
    import cpu_pkg::*;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [4:0]        in_rd;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        alu_opcode;
    logic [DATA_W-1:0] alu_out;
    logic [1:0]        alu_flags;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [4:0]        out_rd;
    logic [4:0]        out_opcode;
    logic              out_wb;
    logic              out_illegal;
    logic [1:0]        flags_q;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [4:0]        rd;
        logic [4:0]        opcode;
        logic              wb;
        logic              illegal;
    } exp_t;

    exp_t sb[$];

    ex_stage #(.DATA_W(DATA_W), .MUL_CYC(2), .DIV_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_opcode  (out_opcode),
        .out_wb      (out_wb),
        .out_illegal (out_illegal),
        .flags_q     (flags_q),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the downstream combinational block.
    function automatic logic [DATA_W-1:0] alu_model(input logic [4:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD, OP_ADDI:         return a + b;
            OP_SUB, OP_SUBI, OP_CMP: return a - b;
            OP_MUL:                  return a * b;
            OP_DIV:                  return (b != 0) ? a / b : '0;
            OP_AND, OP_ANDI:         return a & b;
            OP_OR, OP_ORI:           return a | b;
            OP_XOR, OP_XORI:         return a ^ b;
            OP_NOT:                  return ~a;
            default:                 return a + b;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MOVEH, OP_DIV,
            OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI,
            OP_CMP, OP_CALL, OP_RET, OP_RETI, OP_ST, OP_LD, OP_MOVEL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_wb(input logic [4:0] op);
        if (!is_legal(op)) return 1'b0;
        case (op)
            OP_CMP, OP_ST, OP_CALL, OP_RET, OP_RETI: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        alu_out           = alu_model(alu_opcode, alu_a, alu_b);
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_out == '0);
        alu_flags[FLAG_N] = alu_out[DATA_W-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed=output with opcode %0h expected=no output", out_opcode);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result",  out_result,  e.result);
                chk("sb_rd",      out_rd,      e.rd);
                chk("sb_opcode",  out_opcode,  e.opcode);
                chk("sb_wb",      out_wb,      e.wb);
                chk("sb_illegal", out_illegal, e.illegal);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1; returns in the cycle after the handshake.
    task automatic send(input logic [4:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [4:0] rd,
                        input bit expect_out, input bit chk_ov);
        exp_t e;
        int   n;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        if (expect_out) begin
            e.result  = alu_model(op, a, b);
            e.rd      = rd;
            e.opcode  = op;
            e.wb      = exp_wb(op);
            e.illegal = !is_legal(op);
            sb.push_back(e);
        end
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_ready", in_ready, 1'b1);
        if (chk_ov) chk("b2b_out_valid", out_valid, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish expected=finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = '0;
        in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b1;

        // Reset
        tick(); tick();
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready,   1'b1);
        chk("idle_alu_a",    alu_a,      32'd0);
        chk("idle_flags",    flags_q,    2'b00);
        chk("idle_result",   out_result, 32'd0);
        tick();

        // ADD 5+7
        send(OP_ADD, 32'd5, 32'd7, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_busy",  busy,  1'b1);
        tick();
        @(negedge clk);
        chk("add_out_valid", out_valid,  1'b1);
        chk("add_result",    out_result, 32'd12);
        chk("add_wb",        out_wb,     1'b1);
        chk("add_flags",     flags_q,    2'b00);
        tick();

        // CMP 9 vs 9 then LD
        send(OP_CMP, 32'd9, 32'd9, 5'd2, 1'b1, 1'b0);
        send(OP_LD, 32'h40, 32'd4, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        chk("cmp_opcode", out_opcode, OP_CMP);
        chk("cmp_wb",     out_wb,     1'b0);
        chk("cmp_flags",  flags_q,    2'b10);
        tick();
        @(negedge clk);
        chk("ld_opcode", out_opcode, OP_LD);
        chk("ld_flags",  flags_q,    2'b10);
        tick();

        // DIV 100/7, operands held cycles 1..8
        send(OP_DIV, 32'd100, 32'd7, 5'd4, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("div_alu_a",    alu_a,      32'd100);
            chk("div_alu_b",    alu_b,      32'd7);
            chk("div_alu_op",   alu_opcode, OP_DIV);
            chk("div_in_ready", in_ready,   (k == 8));
            tick();
        end
        @(negedge clk);
        chk("div_out_valid", out_valid,  1'b1);
        chk("div_result",    out_result, 32'd14);
        tick();

        // Four back-to-back ADDs
        send(OP_ADD, 32'd1, 32'd1, 5'd5, 1'b1, 1'b0);
        send(OP_ADD, 32'd2, 32'd2, 5'd6, 1'b1, 1'b0);
        send(OP_ADD, 32'd3, 32'd3, 5'd7, 1'b1, 1'b1);
        send(OP_ADD, 32'd4, 32'd4, 5'd8, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_ov_c4", out_valid, 1'b1);
        tick();
        @(negedge clk);
        chk("b2b_ov_c5", out_valid, 1'b1);
        tick();
        @(negedge clk);
        chk("b2b_ov_c6", out_valid, 1'b0);
        tick();

        // Output stall
        out_ready = 1'b0;
        send(OP_ADD, 32'd10, 32'd20, 5'd9, 1'b1, 1'b0);
        send(OP_ADD, 32'd3, 32'd4, 5'd10, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready",  in_ready,   1'b0);
            chk("stall_busy",      busy,       1'b1);
            chk("stall_out_valid", out_valid,  1'b1);
            chk("stall_alu_a",     alu_a,      32'd3);
            chk("stall_result",    out_result, 32'd30);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in_ready", in_ready, 1'b1);
        tick();
        @(negedge clk);
        chk("unstall_result", out_result, 32'd7);
        tick();

        // MUL killed by flush
        send(OP_MUL, 32'd0, 32'd5, 5'd11, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",     busy,       1'b0);
        chk("flush_ready_c2", in_ready,   1'b1);
        chk("flush_alu_a",    alu_a,      32'd0);
        chk("flush_alu_op",   alu_opcode, 5'd0);
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_out", out_valid,  1'b0);
            chk("flush_flags",  flags_q,    2'b00);
            chk("flush_keep",   out_result, 32'd7);
            tick();
        end

        // Negative CMP, then illegal opcode
        send(OP_CMP, 32'd3, 32'd9, 5'd0, 1'b1, 1'b0);
        send(5'b01001, 32'd1, 32'd2, 5'd12, 1'b1, 1'b0);
        @(negedge clk);
        chk("cmpneg_flags", flags_q, 2'b01);
        tick();
        @(negedge clk);
        chk("ill_illegal", out_illegal, 1'b1);
        chk("ill_wb",      out_wb,      1'b0);
        chk("ill_opcode",  out_opcode,  5'b01001);
        tick();
        @(negedge clk);
        chk("ill_flags", flags_q, 2'b01);
        tick();

        // Reset in the middle of a DIV
        send(OP_DIV, 32'd50, 32'd5, 5'd13, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstdiv_in_ready", in_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("rstdiv_out_valid", out_valid,   1'b0);
        chk("rstdiv_result",    out_result,  32'd0);
        chk("rstdiv_rd",        out_rd,      5'd0);
        chk("rstdiv_opcode",    out_opcode,  5'd0);
        chk("rstdiv_wb",        out_wb,      1'b0);
        chk("rstdiv_illegal",   out_illegal, 1'b0);
        chk("rstdiv_flags",     flags_q,     2'b00);
        chk("rstdiv_busy",      busy,        1'b0);
        chk("rstdiv_alu_a",     alu_a,       32'd0);
        chk("rstdiv_alu_b",     alu_b,       32'd0);
        chk("rstdiv_alu_op",    alu_opcode,  5'd0);
        tick();
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("rstdiv_discard", out_valid, 1'b0);
            tick();
        end

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
